// File: rtl/jamma_joy_scanner.sv
// rtl/jamma_joy_scanner.sv - JAMMA shared joystick bus scanner with settle, sync and debounce

// Two-flop synchroniser for asynchronous switch inputs; idles high (released).
module jamma_joy_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] meta;

  // Double-register the asynchronous bus to resolve metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      dout <= '1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// Sample-qualified debouncer: the output only moves once N identical samples
// in a row have been seen, and only on cycles where en marks a sample slot.
module jamma_joy_debounce #(
  parameter int W = 8,
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] sample,
  output logic [W-1:0] dout
);

  localparam logic [3:0] N_L = 4'(N);

  logic [W-1:0] cand;
  logic [3:0]   cnt;
  logic [3:0]   cnt_next;

  // Next run length: saturates at N on a repeat, restarts at 1 on any change.
  always_comb begin
    cnt_next = 4'd1;
    if (sample == cand) begin
      cnt_next = (cnt >= N_L) ? N_L : cnt + 4'd1;
    end
  end

  // Advance the candidate/run on sample slots and publish once qualified.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= '1;
      cnt  <= 4'd0;
      dout <= '1;
    end else if (en) begin
      cand <= sample;
      cnt  <= cnt_next;
      if (cnt_next == N_L) begin
        dout <= sample;
      end
    end
  end

endmodule

// Top level: alternates JSELECT between the two players, waits for the bus
// mux and synchroniser to settle, then samples and debounces each player.
module jamma_joy_scanner #(
  parameter int SETTLE     = 4,
  parameter int DEBOUNCE_N = 3
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] JJOY,
  input  logic [1:0] JCOIN,
  input  logic [5:0] LOCAL_JOY,
  output logic       JSELECT,
  output logic [7:0] JOY1,
  output logic [7:0] JOY2,
  output logic [1:0] COIN,
  output logic       SCAN_TICK
);

  typedef enum logic [1:0] {
    SETTLE1 = 2'd0,
    SAMPLE1 = 2'd1,
    SETTLE2 = 2'd2,
    SAMPLE2 = 2'd3
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  state_t     state;
  logic [7:0] settle_cnt;
  logic [7:0] jjoy_s;
  logic [1:0] coin_s;
  logic [7:0] p1_sample;
  logic       p1_en;
  logic       p2_en;

  jamma_joy_sync #(.W(8)) u_sync_joy (
    .clk   (CLK),
    .rst_n (RESET_N),
    .din   (JJOY),
    .dout  (jjoy_s)
  );

  jamma_joy_sync #(.W(2)) u_sync_coin (
    .clk   (CLK),
    .rst_n (RESET_N),
    .din   (JCOIN),
    .dout  (coin_s)
  );

  // Scan sequencer: settle, sample P1, switch to P2, settle, sample P2, switch back.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= SETTLE1;
      settle_cnt <= 8'd0;
      JSELECT    <= 1'b0;
      SCAN_TICK  <= 1'b0;
    end else begin
      SCAN_TICK <= 1'b0;
      case (state)
        SETTLE1: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= 8'd0;
            state      <= SAMPLE1;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        SAMPLE1: begin
          JSELECT <= 1'b1;
          state   <= SETTLE2;
        end
        SETTLE2: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= 8'd0;
            state      <= SAMPLE2;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        default: begin
          JSELECT   <= 1'b0;
          SCAN_TICK <= 1'b1;
          state     <= SETTLE1;
        end
      endcase
    end
  end

  // Local joystick is wire-ANDed into player 1 before qualification.
  always_comb begin
    p1_sample = jjoy_s & {2'b11, LOCAL_JOY};
    p1_en     = (state == SAMPLE1);
    p2_en     = (state == SAMPLE2);
  end

  jamma_joy_debounce #(.W(8), .N(DEBOUNCE_N)) u_db_p1 (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .en     (p1_en),
    .sample (p1_sample),
    .dout   (JOY1)
  );

  jamma_joy_debounce #(.W(8), .N(DEBOUNCE_N)) u_db_p2 (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .en     (p2_en),
    .sample (jjoy_s),
    .dout   (JOY2)
  );

  // Coins are only advanced in the P1 slot, so they debounce once per scan.
  jamma_joy_debounce #(.W(2), .N(DEBOUNCE_N)) u_db_coin (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .en     (p1_en),
    .sample (coin_s),
    .dout   (COIN)
  );

endmodule
